select_scheduler: RTL and testbench
===================================

# select_scheduler

Sequencing controller for the per-value selector array. It holds a table of K requester slots, each tagged with a key in 0..SIZE-1. On `start` it sweeps keys in ascending order and grants, one per handshake, every requester whose key matches the current sweep value, lowest slot index first. This turns the array's static value-to-index mapping into an ordered, flow-controlled stream of grants for the downstream shared resource.

## Interface
- `SIZE`, 16: key range; keys are `$clog2(SIZE)` bits wide.
- `K`, 8: number of requester slots; indices are `$clog2(K)` bits wide.

- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `load_valid` input 1: write request for one table slot.
- `load_ready` output 1: table writable; 1 only in IDLE.
- `load_idx` input $clog2(K): slot to write.
- `load_key` input $clog2(SIZE): key stored in the slot.
- `start` input 1: begin a sweep; sampled only in IDLE.
- `busy` output 1: high in SCAN and DONE.
- `grant_valid` output 1: a grant is offered.
- `grant_ready` input 1: consumer accepts the grant.
- `grant_idx` output $clog2(K): granted slot index.
- `grant_key` output $clog2(SIZE): key of the granted slot (equals the sweep cursor).
- `done` output 1: one-cycle pulse when the sweep completes.

## Operation
- State: K slot-valid bits, K key registers, a cursor of `$clog2(SIZE)` bits, and an FSM with states IDLE, SCAN and DONE.
- **Load (IDLE):**
  - `load_valid && load_ready` sets `valid[load_idx]` and writes `key[load_idx]`.
  - Rewriting an occupied slot overwrites its key; no duplicate entry is created.
- **Start:**
  - `start` in IDLE moves the FSM to SCAN with cursor = 0.
  - A load in the same cycle as `start` is committed and takes part in the sweep.
- **Match:**
  - `match[j] = valid[j] && key[j] == cursor`.
  - `grant_valid = (state == SCAN) && |match`.
  - `grant_idx` is the lowest j with `match[j]` set; `grant_key` equals the cursor.
- **SCAN step on each cycle:**
  - On a handshake (`grant_valid && grant_ready`), clear `valid[grant_idx]`.
  - If other matches remain at the cursor, hold the cursor.
  - Otherwise advance the cursor.
  - With no match, advance the cursor.
  - With `grant_valid && !grant_ready`, hold the cursor; `grant_idx` and `grant_key` stay stable.
- **End of sweep:** advancing from cursor = SIZE-1 does not wrap. The FSM goes to DONE instead.
- **DONE:** `done` = 1 for exactly one cycle, then the FSM returns to IDLE. The table is empty at that point.
- **Busy states:** `start` and loads are ignored in SCAN and DONE (`load_ready` = 0).
- **Empty table on start:** the sweep runs to completion with no grants.
- **Reset:**
  - State goes to IDLE, all valid bits clear, cursor = 0.
  - `load_ready` = 1; `busy`, `grant_valid` and `done` = 0.
  - `grant_idx` and `grant_key` = 0.
  - Reset during SCAN discards any pending grants.

## Timing
- Grant outputs are combinational from registered state; there are no input-to-output combinational paths except `grant_ready` → next-state logic.
- `start` is sampled at edge t. The first SCAN cycle is t+1, with cursor = 0.
- With `grant_ready` held at 1, a key with m matching slots costs max(1, m) cycles. Sweep length = Σ over keys of max(1, m).
- `done` asserts the cycle after the final SCAN cycle. `load_ready` returns to 1 in the following cycle.
- Back-to-back grants are possible every cycle, including across keys.

## Configuration
- `SCHED_SKIP_EN` defined:
  - Each cursor advance jumps to the lowest key greater than the cursor held by any valid slot, found by a priority search over the table.
  - If no such key exists, the FSM goes directly to DONE.
  - If cursor 0 is unoccupied at start, the first SCAN cycle already sits on the lowest occupied key.
  - Empty keys cost zero cycles, so a sweep of n entries takes n cycles with `grant_ready` = 1.
  - An empty table goes IDLE → DONE after `start`, skipping SCAN.
- Undefined: the cursor steps by one per advance, as described in Operation.

## Structure
- A shared package holds:
  - the state enum (IDLE, SCAN, DONE);
  - the width localparams `IDX_W = $clog2(K)` and `KEY_W = $clog2(SIZE)`;
  - a slot struct {valid, key}.
- Sub-module `slot_match`: combinational match vector and lowest-index encoder. It takes the cursor and the table and returns `any_match`, `grant_idx` and `multi_match`. Use one instance in the scheduler.

## Test plan
- **Basic ascending order:** K=8, SIZE=16. Load slot3 = key 5, slot1 = key 2, slot6 = key 9; `start`; `grant_ready` = 1. Expect grants idx 1/key 2, idx 3/key 5, idx 6/key 9. Expect `done` at cycle 17 after `start` without skip, or cycle 4 with `SCHED_SKIP_EN`.
- **Tie on one key:** slots 4, 0 and 2 all hold key 7. Expect grants in order idx 0, 2, 4 on consecutive cycles, all with key 7.
- **Backpressure:** slot5 = key 3; `grant_ready` = 0 for 4 cycles, then 1. Expect `grant_valid` held with idx 5/key 3 stable for all 4 cycles and the cursor not advancing. Expect exactly one grant.
- **Empty sweep and ignored inputs:** `start` with an empty table. Expect no `grant_valid`, `done` after 16 SCAN cycles (or at t+1 with skip). Expect `load_ready` = 0 throughout SCAN; a `load_valid` pulse during SCAN leaves the table unchanged.
- **Overwrite and same-cycle load:** load slot2 = key 1, then slot2 = key 8; in the next cycle load slot0 = key 8 together with `start`. Expect exactly two grants, idx 0 then idx 2, both with key 8.
- **Reset mid-sweep:** assert `rst` during the second of three pending grants. The next cycle shows IDLE with all outputs at reset values. A fresh `start` produces no grants.

Source files
------------

// File: rtl/select_scheduler_pkg.sv
// Shared types and widths for the select_scheduler slice: FSM states, slot record,
// and the key search used by the optional skip-ahead cursor.
package select_scheduler_pkg;

   localparam int SIZE  = 16;
   localparam int K     = 8;
   localparam int IDX_W = $clog2(K);
   localparam int KEY_W = $clog2(SIZE);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_e;

   typedef struct packed {
      logic             valid;
      logic [KEY_W-1:0] key;
   } slot_t;

   typedef slot_t [K-1:0] slot_tbl_t;

   typedef struct packed {
      logic             found;
      logic [KEY_W-1:0] key;
   } key_search_t;

   // Smallest key held by a valid slot that lies above floor_key (or equals it when inclusive).
   function automatic key_search_t next_key(input slot_tbl_t        tbl,
                                            input logic [KEY_W-1:0] floor_key,
                                            input logic             inclusive);
      key_search_t res;
      res.found = 1'b0;
      res.key   = '0;
      for (int j = 0; j < K; j++) begin
         if (tbl[j].valid &&
             ((tbl[j].key > floor_key) || (inclusive && (tbl[j].key == floor_key))) &&
             (!res.found || (tbl[j].key < res.key))) begin
            res.found = 1'b1;
            res.key   = tbl[j].key;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/select_scheduler_if.sv
// Load/start/grant bundle between the scheduler (slave) and its user (master).
interface select_scheduler_if;
   import select_scheduler_pkg::*;

   logic             load_valid;
   logic             load_ready;
   logic [IDX_W-1:0] load_idx;
   logic [KEY_W-1:0] load_key;
   logic             start;
   logic             busy;
   logic             grant_valid;
   logic             grant_ready;
   logic [IDX_W-1:0] grant_idx;
   logic [KEY_W-1:0] grant_key;
   logic             done;

   modport master (
      output load_valid, load_idx, load_key, start, grant_ready,
      input  load_ready, busy, grant_valid, grant_idx, grant_key, done
   );

   modport slave (
      input  load_valid, load_idx, load_key, start, grant_ready,
      output load_ready, busy, grant_valid, grant_idx, grant_key, done
   );

endinterface

// File: rtl/select_scheduler_slot_match.sv
// Combinational compare of every slot against the cursor, returning the lowest
// matching index and whether more than one slot matches.
module slot_match
   import select_scheduler_pkg::*;
(
   input  logic [KEY_W-1:0] cursor_i,
   input  slot_tbl_t        slots_i,
   output logic             any_match_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             multi_match_o
);

   logic [K-1:0] match;

   // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      any_match_o   = 1'b0;
      multi_match_o = 1'b0;
      grant_idx_o   = '0;
      match         = '0;
      for (int j = 0; j < K; j++) begin
         match[j] = slots_i[j].valid && (slots_i[j].key == cursor_i);
         if (match[j]) begin
            if (any_match_o) begin
               multi_match_o = 1'b1;
            end else begin
               grant_idx_o = IDX_W'(j);
            end
            any_match_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/select_scheduler.sv
// Ordered grant sequencer: sweeps keys ascending and grants matching slots lowest index first.
// Define SCHED_SKIP_EN to jump the cursor straight to the next occupied key.
module select_scheduler
   import select_scheduler_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   select_scheduler_if.slave  bus
);

   state_e           state_q, state_d;
   logic [KEY_W-1:0] cursor_q, cursor_d;
   slot_tbl_t        slots_q, slots_d;
   slot_tbl_t        slots_load;

   logic             any_match;
   logic             multi_match;
   logic [IDX_W-1:0] match_idx;

   logic             adv_last;
   logic [KEY_W-1:0] adv_cursor;
   logic             start_empty;
   logic [KEY_W-1:0] start_cursor;

   slot_match u_slot_match (
      .cursor_i      (cursor_q),
      .slots_i       (slots_q),
      .any_match_o   (any_match),
      .grant_idx_o   (match_idx),
      .multi_match_o (multi_match)
   );

   // Table as it will look after this cycle's load, so a load beside start joins the sweep.
   always_comb begin
      slots_load = slots_q;
      if ((state_q == IDLE) && bus.load_valid) begin
         slots_load[bus.load_idx].valid = 1'b1;
         slots_load[bus.load_idx].key   = bus.load_key;
      end
   end

`ifdef SCHED_SKIP_EN
   key_search_t first_s;
   key_search_t above_s;

   // A grant only ever clears a slot at the cursor, so searching above it ignores that clear.
   always_comb begin
      first_s      = next_key(slots_load, '0, 1'b1);
      above_s      = next_key(slots_q, cursor_q, 1'b0);
      start_empty  = !first_s.found;
      start_cursor = first_s.key;
      adv_last     = !above_s.found;
      adv_cursor   = above_s.key;
   end
`else
   always_comb begin
      start_empty  = 1'b0;
      start_cursor = '0;
      adv_last     = (cursor_q == KEY_W'(SIZE - 1));
      adv_cursor   = cursor_q + 1'b1;
   end
`endif

   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      slots_d  = slots_q;
      unique case (state_q)
         IDLE: begin
            slots_d = slots_load;
            if (bus.start) begin
               cursor_d = start_cursor;
               state_d  = start_empty ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (any_match && bus.grant_ready) begin
               slots_d[match_idx].valid = 1'b0;
            end
            // Move on once the cursor has nothing left to offer after this cycle.
            if (!any_match || (bus.grant_ready && !multi_match)) begin
               if (adv_last) begin
                  state_d = DONE;
               end else begin
                  cursor_d = adv_cursor;
               end
            end
         end
         DONE: begin
            state_d  = IDLE;
            cursor_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cursor_q <= '0;
         // NOTE: only valid bits are reset; keys are don't-care until their slot is written.
         for (int j = 0; j < K; j++) begin
            slots_q[j].valid <= 1'b0;
         end
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
         slots_q  <= slots_d;
      end
   end

   assign bus.load_ready  = (state_q == IDLE);
   assign bus.busy        = (state_q == SCAN) || (state_q == DONE);
   assign bus.done        = (state_q == DONE);
   assign bus.grant_valid = (state_q == SCAN) && any_match;
   assign bus.grant_idx   = match_idx;
   assign bus.grant_key   = cursor_q;

endmodule

// File: tb/tb_select_scheduler.sv
// Directed bench for select_scheduler: a schedule-list model checked every cycle, plus
// hand-computed grant orders and done latencies. Honours SCHED_SKIP_EN.
module tb_select_scheduler;
   import select_scheduler_pkg::*;

`ifdef SCHED_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   localparam int P_IDLE = 0;
   localparam int P_SCAN = 1;
   localparam int P_DONE = 2;

   logic clk = 1'b0;
   logic rst;

   select_scheduler_if bus ();

   select_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: at start the whole sweep is laid out as a list of steps (a grant, or an empty key
   // that costs one cycle); each cycle consumes the head unless a grant is stalled.
   typedef struct {
      bit is_grant;
      int idx;
      int key;
   } step_t;

   step_t sched[$];
   bit    mdl_valid[K];
   int    mdl_key[K];
   int    phase = P_IDLE;
   bit    live  = 1'b0;

   function automatic void build_sched();
      sched.delete();
      for (int k = 0; k < SIZE; k++) begin
         bit hit = 1'b0;
         for (int j = 0; j < K; j++) begin
            if (mdl_valid[j] && (mdl_key[j] == k)) begin
               sched.push_back('{1'b1, j, k});
               hit = 1'b1;
            end
         end
         if (!hit && !SKIP) sched.push_back('{1'b0, 0, k});
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         live  = 1'b1;
         phase = P_IDLE;
         sched.delete();
         for (int j = 0; j < K; j++) mdl_valid[j] = 1'b0;
      end else if (live) begin
         case (phase)
            P_IDLE: begin
               if (bus.load_valid) begin
                  mdl_valid[bus.load_idx] = 1'b1;
                  mdl_key[bus.load_idx]   = int'(bus.load_key);
               end
               if (bus.start) begin
                  build_sched();
                  phase = (sched.size() == 0) ? P_DONE : P_SCAN;
               end
            end
            P_SCAN: begin
               if (sched[0].is_grant) begin
                  if (bus.grant_ready) begin
                     mdl_valid[sched[0].idx] = 1'b0;
                     void'(sched.pop_front());
                  end
               end else begin
                  void'(sched.pop_front());
               end
               if (sched.size() == 0) phase = P_DONE;
            end
            default: phase = P_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (live && !rst) begin
         bit exp_gv;
         exp_gv = (phase == P_SCAN) && (sched.size() > 0) && sched[0].is_grant;
         check("load_ready", bus.load_ready, phase == P_IDLE);
         check("busy", bus.busy, phase != P_IDLE);
         check("done", bus.done, phase == P_DONE);
         check("grant_valid", bus.grant_valid, exp_gv);
         if ((phase == P_SCAN) && (sched.size() > 0)) check("grant_key", bus.grant_key, sched[0].key);
         if (exp_gv) check("grant_idx", bus.grant_idx, sched[0].idx);
      end
   end

   // Grant log for the literal expectations.
   int log_idx[$];
   int log_key[$];
   int log_cyc[$];
   int cyc_ctr = 0;

   always @(posedge clk) cyc_ctr++;

   always @(negedge clk) begin
      if (!rst && (bus.grant_valid === 1'b1) && (bus.grant_ready === 1'b1)) begin
         log_idx.push_back(int'(bus.grant_idx));
         log_key.push_back(int'(bus.grant_key));
         log_cyc.push_back(cyc_ctr);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input int key);
      bus.load_valid = 1'b1;
      bus.load_idx   = IDX_W'(idx);
      bus.load_key   = KEY_W'(key);
      step();
      bus.load_valid = 1'b0;
   endtask

   task automatic start_sweep();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic clear_log();
      log_idx.delete();
      log_key.delete();
      log_cyc.delete();
   endtask

   // Called in the first cycle after the start edge (cycle 1); returns the cycle done is seen.
   task automatic run_until_done(output int cyc);
      cyc = 1;
      while ((bus.done !== 1'b1) && (cyc < 200)) begin
         step();
         cyc++;
      end
      if (bus.done !== 1'b1) check("done_timeout", bus.done, 1);
      step();
   endtask

   task automatic check_log(input string tag, input int ei[$], input int ek[$]);
      check({tag, "_count"}, log_idx.size(), ei.size());
      for (int i = 0; i < ei.size(); i++) begin
         if (i < log_idx.size()) begin
            check($sformatf("%s_idx%0d", tag, i), log_idx[i], ei[i]);
            check($sformatf("%s_key%0d", tag, i), log_key[i], ek[i]);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_load_ready"}, bus.load_ready, 1);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_grant_valid"}, bus.grant_valid, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_grant_idx"}, bus.grant_idx, 0);
      check({tag, "_grant_key"}, bus.grant_key, 0);
   endtask

   initial begin
      int c;
      int w;
      int found;
      int ei[$];
      int ek[$];

      rst             = 1'b1;
      bus.load_valid  = 1'b0;
      bus.load_idx    = '0;
      bus.load_key    = '0;
      bus.start       = 1'b0;
      bus.grant_ready = 1'b1;
      step();
      step();
      check_reset_outputs("reset");
      rst = 1'b0;
      step();

      // Basic ascending order.
      load(3, 5);
      load(1, 2);
      load(6, 9);
      clear_log();
      start_sweep();
      run_until_done(c);
      check("basic_done_cycle", c, SKIP ? 4 : 17);
      ei = '{1, 3, 6};
      ek = '{2, 5, 9};
      check_log("basic", ei, ek);

      // Tie on one key: consecutive grants, lowest slot first.
      load(4, 7);
      load(0, 7);
      load(2, 7);
      clear_log();
      start_sweep();
      run_until_done(c);
      check("tie_done_cycle", c, SKIP ? 4 : 19);
      ei = '{0, 2, 4};
      ek = '{7, 7, 7};
      check_log("tie", ei, ek);
      if (log_cyc.size() == 3) begin
         check("tie_gap01", log_cyc[1] - log_cyc[0], 1);
         check("tie_gap12", log_cyc[2] - log_cyc[1], 1);
      end

      // Backpressure: grant held stable while the consumer stalls.
      bus.grant_ready = 1'b0;
      load(5, 3);
      clear_log();
      start_sweep();
      w = 0;
      while ((bus.grant_valid !== 1'b1) && (w < 40)) begin
         step();
         w++;
      end
      check("bp_first_grant_wait", w, SKIP ? 0 : 3);
      for (int i = 0; i < 4; i++) begin
         check("bp_hold_valid", bus.grant_valid, 1);
         check("bp_hold_idx", bus.grant_idx, 5);
         check("bp_hold_key", bus.grant_key, 3);
         step();
      end
      bus.grant_ready = 1'b1;
      run_until_done(c);
      check("bp_done_cycle", c, SKIP ? 2 : 14);
      ei = '{5};
      ek = '{3};
      check_log("bp", ei, ek);

      // Empty sweep; a load pulse while busy must be ignored.
      clear_log();
      start_sweep();
      check("empty_load_ready", bus.load_ready, 0);
      bus.load_valid = 1'b1;
      bus.load_idx   = IDX_W'(1);
      bus.load_key   = KEY_W'(9);
      c     = 1;
      found = 0;
      while ((found == 0) && (c <= 40)) begin
         if (bus.done === 1'b1) begin
            found = c;
         end else begin
            step();
            bus.load_valid = 1'b0;
            c++;
         end
      end
      check("empty_done_cycle", found, SKIP ? 1 : 17);
      step();
      bus.load_valid = 1'b0;
      check("empty_grants", log_idx.size(), 0);

      // Overwrite of a slot, then a load committed in the same cycle as start.
      load(2, 1);
      load(2, 8);
      clear_log();
      bus.load_valid = 1'b1;
      bus.load_idx   = IDX_W'(0);
      bus.load_key   = KEY_W'(8);
      bus.start      = 1'b1;
      step();
      bus.load_valid = 1'b0;
      bus.start      = 1'b0;
      run_until_done(c);
      check("ovw_done_cycle", c, SKIP ? 3 : 18);
      ei = '{0, 2};
      ek = '{8, 8};
      check_log("ovw", ei, ek);

      // Reset in the middle of a three-grant key.
      load(1, 0);
      load(4, 0);
      load(6, 0);
      clear_log();
      start_sweep();
      step();
      check("rst_mid_idx", bus.grant_idx, 4);
      check("rst_mid_valid", bus.grant_valid, 1);
      rst = 1'b1;
      step();
      check_reset_outputs("rst_mid");
      rst = 1'b0;
      clear_log();
      start_sweep();
      run_until_done(c);
      check("rst_fresh_done_cycle", c, SKIP ? 1 : 17);
      check("rst_fresh_grants", log_idx.size(), 0);

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
